spram_arbiter: RTL and testbench

SPRAM_ARBITER -- requirements
Module: spram_arbiter

---
 rtl/spram_pkg.sv | 17 +
 rtl/rr_arb2.sv | 20 ++
 rtl/spram_arbiter.sv | 117 +++++++++++
 tb/tb_spram_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_pkg.sv
// Shared constants and pipeline record for the single-port RAM arbiter.
package spram_pkg;

  localparam int unsigned MEM_DEPTH_DEF = 1920;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // One in-flight request as it moves through the two pipeline stages.
  typedef struct packed {
    logic valid;
    logic owner;
    logic we;
    logic err;
  } stage_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: on a tie the requester other than lp wins.
module rr_arb2
  import spram_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lp,
  output logic [1:0] gnt
);

  // Tie goes to the requester that was not served last; a lone requester always wins.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = (lp == REQ0) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/spram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with a two-stage
// command/acknowledge pipeline.
module spram_arbiter
  import spram_pkg::*;
#(
  parameter int unsigned PARAM_WIDTH = 11,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MEM_DEPTH   = MEM_DEPTH_DEF
) (
  input  logic                   I_CLK,
  input  logic                   I_RST,
  input  logic                   i_req0,
  input  logic                   i_req1,
  input  logic                   i_we0,
  input  logic                   i_we1,
  input  logic [PARAM_WIDTH-1:0] i_addr0,
  input  logic [PARAM_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0]  i_din0,
  input  logic [DATA_WIDTH-1:0]  i_din1,
  output logic                   o_gnt0,
  output logic                   o_gnt1,
  output logic                   o_ack0,
  output logic                   o_ack1,
  output logic                   o_err0,
  output logic                   o_err1,
  output logic [DATA_WIDTH-1:0]  o_rdata,
  output logic                   o_ram_cs,
  output logic                   o_ram_we,
  output logic [PARAM_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0]  o_ram_din,
  input  logic [DATA_WIDTH-1:0]  i_ram_dout
);

  logic                   lp;
  logic [1:0]             arb_gnt;
  logic                   accept;
  logic                   sel;
  logic                   sel_we;
  logic [PARAM_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]  sel_din;
  logic                   sel_err;
  logic                   sel_go;
  stage_t                 s1;
  stage_t                 s2;

  rr_arb2 u_rr_arb2 (
    .req ({i_req1, i_req0}),
    .lp  (lp),
    .gnt (arb_gnt)
  );

  // Grants are suppressed while reset is held so nothing is accepted then.
  assign o_gnt0 = arb_gnt[0] & ~I_RST;
  assign o_gnt1 = arb_gnt[1] & ~I_RST;
  assign accept = o_gnt0 | o_gnt1;
  assign sel    = o_gnt1 ? REQ1 : REQ0;

  // Command of the granted requester; the other requester's fields are ignored.
  always_comb begin
    sel_we   = i_we0;
    sel_addr = i_addr0;
    sel_din  = i_din0;
    if (sel == REQ1) begin
      sel_we   = i_we1;
      sel_addr = i_addr1;
      sel_din  = i_din1;
    end
  end

  // Out-of-range addresses still use the slot but never reach the RAM.
  assign sel_err = 32'(sel_addr) >= MEM_DEPTH;
  assign sel_go  = accept & ~sel_err;

  // Last-served pointer; reset value lets requester 0 win the first tie.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      lp <= REQ1;
    end else if (accept) begin
      lp <= sel;
    end
  end

  // Stage 1: issue the accepted command to the RAM.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      s1         <= '0;
      o_ram_cs   <= 1'b0;
      o_ram_we   <= 1'b0;
      o_ram_addr <= '0;
      o_ram_din  <= '0;
    end else begin
      s1       <= '{valid: accept, owner: sel, we: sel_we, err: sel_err};
      o_ram_cs <= sel_go;
      o_ram_we <= sel_go & sel_we;
      if (sel_go) begin
        o_ram_addr <= sel_addr;
        o_ram_din  <= sel_din;
      end
    end
  end

  // Stage 2: completion slot, aligned with the RAM's registered read data.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      s2 <= '0;
    end else begin
      s2 <= s1;
    end
  end

  assign o_ack0  = s2.valid & (s2.owner == REQ0);
  assign o_ack1  = s2.valid & (s2.owner == REQ1);
  assign o_err0  = o_ack0 & s2.err;
  assign o_err1  = o_ack1 & s2.err;
  assign o_rdata = (s2.valid & ~s2.we & ~s2.err) ? i_ram_dout : '0;

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: behavioural RAM, grant table, scoreboard of acks.
module tb_spram_arbiter;

  logic        I_CLK;
  logic        I_RST;
  logic        i_req0, i_req1, i_we0, i_we1;
  logic [10:0] i_addr0, i_addr1;
  logic [7:0]  i_din0, i_din1;
  logic        o_gnt0, o_gnt1, o_ack0, o_ack1, o_err0, o_err1;
  logic [7:0]  o_rdata;
  logic        o_ram_cs, o_ram_we;
  logic [10:0] o_ram_addr;
  logic [7:0]  o_ram_din;
  logic [7:0]  ram_dout;

  spram_arbiter #(.PARAM_WIDTH(11), .DATA_WIDTH(8), .MEM_DEPTH(1920)) dut (
    .I_CLK      (I_CLK),
    .I_RST      (I_RST),
    .i_req0     (i_req0),
    .i_req1     (i_req1),
    .i_we0      (i_we0),
    .i_we1      (i_we1),
    .i_addr0    (i_addr0),
    .i_addr1    (i_addr1),
    .i_din0     (i_din0),
    .i_din1     (i_din1),
    .o_gnt0     (o_gnt0),
    .o_gnt1     (o_gnt1),
    .o_ack0     (o_ack0),
    .o_ack1     (o_ack1),
    .o_err0     (o_err0),
    .o_err1     (o_err1),
    .o_rdata    (o_rdata),
    .o_ram_cs   (o_ram_cs),
    .o_ram_we   (o_ram_we),
    .o_ram_addr (o_ram_addr),
    .o_ram_din  (o_ram_din),
    .i_ram_dout (ram_dout)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  // Single-port RAM with registered read data.
  logic [7:0] ram [0:2047];
  always @(posedge I_CLK) begin
    if (o_ram_cs) begin
      if (o_ram_we) ram[o_ram_addr] <= o_ram_din;
      else          ram_dout <= ram[o_ram_addr];
    end
  end

  typedef struct {
    logic       owner;
    logic       err;
    logic [7:0] data;
    int         due;
  } exp_t;

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [10:0] a0, a1;
    logic [7:0]  d0, d1;
    logic [1:0]  eg;
  } vec_t;

  exp_t       q[$];
  logic [7:0] shadow [0:2047];
  vec_t       vecs [10];
  int         checks;
  int         failures;
  int         cyc;
  logic [1:0] last_g;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Per-cycle observation: score acks against the queue, then log new grants.
  task automatic monitor();
    exp_t       e;
    logic [10:0] a;
    logic        we;
    logic [7:0]  d;
    logic        idx;
    cyc++;
    last_g = {o_gnt1, o_gnt0};
    if (I_RST) begin
      q.delete();
      return;
    end
    chk("gnt_count", 32'($countones({o_gnt1, o_gnt0}) <= 1), 32'd1);
    if (o_ack0 || o_ack1) begin
      if (q.size() == 0) begin
        chk("spurious_ack", 32'({o_ack1, o_ack0}), 32'd0);
      end else begin
        e = q.pop_front();
        chk("ack_owner", 32'({o_ack1, o_ack0}), e.owner ? 32'd2 : 32'd1);
        chk("ack_err", 32'(e.owner ? o_err1 : o_err0), 32'(e.err));
        chk("ack_err_other", 32'(e.owner ? o_err0 : o_err1), 32'd0);
        chk("ack_rdata", 32'(o_rdata), 32'(e.data));
        chk("ack_latency", 32'(cyc), 32'(e.due));
      end
    end else begin
      if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("missing_ack", 32'({o_ack1, o_ack0}), e.owner ? 32'd2 : 32'd1);
      end
      chk("idle_err", 32'({o_err1, o_err0}), 32'd0);
      chk("idle_rdata", 32'(o_rdata), 32'd0);
    end
    if (o_gnt0 || o_gnt1) begin
      idx = o_gnt1;
      we  = idx ? i_we1 : i_we0;
      a   = idx ? i_addr1 : i_addr0;
      d   = idx ? i_din1 : i_din0;
      e.owner = idx;
      e.err   = (a >= 11'd1920);
      e.data  = (!we && !e.err) ? shadow[a] : 8'h00;
      e.due   = cyc + 2;
      if (we && !e.err) shadow[a] = d;
      q.push_back(e);
    end
  endtask

  task automatic cycle();
    @(negedge I_CLK);
    monitor();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic drive(input logic r0, input logic r1, input logic w0, input logic w1,
                       input logic [10:0] a0, input logic [10:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    i_req0 = r0; i_req1 = r1; i_we0 = w0; i_we1 = w1;
    i_addr0 = a0; i_addr1 = a1; i_din0 = d0; i_din1 = d1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 11'h0, 11'h0, 8'h0, 8'h0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Hold reset with both requesters active; everything must read zero.
  task automatic do_reset();
    I_RST = 1'b1;
    drive(1, 1, 1, 1, 11'h3, 11'h4, 8'hFF, 8'hEE);
    cycle();
    cycle();
    chk("rst_gnt", 32'({o_gnt1, o_gnt0}), 32'd0);
    chk("rst_ack", 32'({o_ack1, o_ack0}), 32'd0);
    chk("rst_err", 32'({o_err1, o_err0}), 32'd0);
    chk("rst_rdata", 32'(o_rdata), 32'd0);
    chk("rst_ram_cs_we", 32'({o_ram_cs, o_ram_we}), 32'd0);
    chk("rst_ram_addr", 32'(o_ram_addr), 32'd0);
    chk("rst_ram_din", 32'(o_ram_din), 32'd0);
    I_RST = 1'b0;
    drive(0, 0, 0, 0, 11'h0, 11'h0, 8'h0, 8'h0);
  endtask

  function automatic vec_t mk(input logic r0, input logic r1, input logic w0, input logic w1,
                              input logic [10:0] a0, input logic [10:0] a1,
                              input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] eg);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.eg = eg;
    return v;
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    last_g = 2'b00;
    for (int i = 0; i < 2048; i++) shadow[i] = 8'h00;
    I_RST = 1'b1;
    drive(0, 0, 0, 0, 11'h0, 11'h0, 8'h0, 8'h0);

    // Grant table, starting from reset (requester 0 wins the first tie).
    vecs[0] = mk(1, 0, 1, 0, 11'h010, 11'h000, 8'h11, 8'h00, 2'b01);
    vecs[1] = mk(1, 0, 0, 0, 11'h010, 11'h000, 8'h00, 8'h00, 2'b01);
    vecs[2] = mk(1, 1, 0, 0, 11'h010, 11'h010, 8'h00, 8'h00, 2'b10);
    vecs[3] = mk(0, 1, 0, 1, 11'h000, 11'h011, 8'h00, 8'h22, 2'b10);
    vecs[4] = mk(1, 1, 0, 0, 11'h7FF, 11'h011, 8'h00, 8'h00, 2'b01);
    vecs[5] = mk(0, 0, 1, 1, 11'h010, 11'h011, 8'hDE, 8'hAD, 2'b00);
    vecs[6] = mk(1, 1, 1, 0, 11'h012, 11'h012, 8'h33, 8'h00, 2'b10);
    vecs[7] = mk(1, 1, 1, 0, 11'h012, 11'h012, 8'h33, 8'h00, 2'b01);
    vecs[8] = mk(0, 1, 0, 0, 11'h000, 11'h012, 8'h00, 8'h00, 2'b10);
    vecs[9] = mk(0, 0, 0, 0, 11'h000, 11'h000, 8'h00, 8'h00, 2'b00);

    @(posedge I_CLK);
    #1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].r0, vecs[i].r1, vecs[i].w0, vecs[i].w1,
            vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      cycle();
      chk($sformatf("vec%0d_gnt", i), 32'(last_g), 32'(vecs[i].eg));
    end
    idle(4);

    // Write 0x005 by requester 0, immediately read back by requester 1.
    drive(1, 0, 1, 0, 11'h005, 11'h000, 8'hA5, 8'h00);
    cycle();
    chk("wr_then_rd_gnt0", 32'(last_g), 32'd1);
    drive(0, 1, 0, 0, 11'h000, 11'h005, 8'h00, 8'h00);
    cycle();
    chk("wr_then_rd_gnt1", 32'(last_g), 32'd2);
    idle(4);

    // Preload 0x000-0x003, then four back-to-back reads by requester 1.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 1, 11'h000, 11'(i), 8'h00, 8'(8'h10 + i));
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 11'h000, 11'(i), 8'h00, 8'h00);
      cycle();
      chk("burst_gnt", 32'(last_g), 32'd2);
    end
    idle(4);

    // Both requesting continuously after reset: strict alternation from 0.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, 0, 11'h010, 11'h011, 8'h00, 8'h00);
      cycle();
      chk("alternate_gnt", 32'(last_g), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    idle(4);

    // First out-of-range address: no RAM access, error ack with zero data.
    drive(1, 0, 0, 0, 11'h780, 11'h000, 8'h00, 8'h00);
    cycle();
    drive(0, 0, 0, 0, 11'h000, 11'h000, 8'h00, 8'h00);
    chk("oor_ram_cs", 32'(o_ram_cs), 32'd0);
    cycle();
    cycle();
    idle(3);

    // Reset one cycle after an accepted read discards it; tie then goes to 0.
    drive(1, 0, 0, 0, 11'h010, 11'h000, 8'h00, 8'h00);
    cycle();
    chk("pre_rst_gnt", 32'(last_g), 32'd1);
    I_RST = 1'b1;
    drive(1, 1, 0, 0, 11'h010, 11'h011, 8'h00, 8'h00);
    cycle();
    chk("in_rst_gnt", 32'(last_g), 32'd0);
    I_RST = 1'b0;
    chk("post_rst_ack", 32'({o_ack1, o_ack0}), 32'd0);
    chk("post_rst_err", 32'({o_err1, o_err0}), 32'd0);
    chk("post_rst_rdata", 32'(o_rdata), 32'd0);
    chk("post_rst_ram", 32'({o_ram_cs, o_ram_we}), 32'd0);
    cycle();
    chk("post_rst_tie_gnt", 32'(last_g), 32'd1);
    idle(4);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
